regfile_uart_dump: RTL and testbench
====================================

Name: regfile_uart_dump

Overview:
- Hardware-side reader of the CPU register file: on a start request, walks the register file through a read port and streams every register over an 8N1 UART TX line.
- Lets the FPGA build report program results (e.g. x3 after the branch program) to a host PC without simulation visibility.
- Sits beside cpu_top; taps a spare combinational read port of the register file.

Parameters:
- CLKS_PER_BIT, 868, clock cycles per UART bit (100 MHz / 115200); legal range >= 2.
- NREGS, 32, number of registers dumped, addresses 0..NREGS-1; legal range 1..32.

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  dump request, level-sampled only while idle.
- rf_addr  out  5  register-file read address, registered.
- rf_data  in  32  register-file read data, combinational from rf_addr.
- tx  out  1  UART serial output, idle high.
- busy  out  1  high while a dump is in progress.
- done  out  1  one-cycle pulse when the final stop bit completes.

Behaviour:
- Reset (rst=0, async): tx=1, busy=0, done=0, rf_addr=0. FSM goes to IDLE, all counters clear, shift register clears.
- Reset mid-operation aborts immediately. There is no done pulse and no partial completion. After reset releases, the block waits for a new start.
- Stream format: header byte 0xA5, then for each register 0..NREGS-1, 4 bytes little-endian. With DUMP_CHECKSUM_EN, a checksum byte follows.
- Byte framing: 1 start bit (0), 8 data bits LSB first, 1 stop bit (1). Each bit holds exactly CLKS_PER_BIT cycles, so each byte takes 10*CLKS_PER_BIT cycles.
- FSM states: IDLE, HDR, FETCH, LATCH, SEND, (CKSUM), FIN.
- IDLE -> HDR on a clock edge with start=1. In the following cycle busy=1 and tx=0 (header start bit begins).
- HDR -> FETCH when the header stop bit ends.
- FETCH (1 cycle): rf_addr = current index, tx=1.
- LATCH (1 cycle): capture rf_data into a 32-bit holding register, tx=1.
- SEND: transmit the 4 bytes back-to-back, with no gap between bytes.
- After SEND, if index < NREGS-1: increment index and go to FETCH. Otherwise go to CKSUM if enabled, else FIN.
- FIN (1 cycle): done=1 and busy=0 in this same cycle, tx=1, then go to IDLE.
- Latency, start edge to done: 1 + 10*CLKS_PER_BIT*(1+4*NREGS) + 2*NREGS cycles (+10*CLKS_PER_BIT with checksum).
- start while busy=1 is ignored; it is neither queued nor a restart.
- start held high through FIN: a new dump is accepted on the edge after FIN.
- Each register is sampled at its own LATCH cycle. The dump is not an atomic snapshot; halt the CPU first if coherence is needed.
- rf_addr holds its last value between dumps.
- The index counter is 6 bits so NREGS=32 terminates without wrap.

Optional Feature:
- Macro: DUMP_CHECKSUM_EN.
- Defined: after the last register byte, send one extra byte equal to the XOR of all register data bytes (header excluded), framed identically. The accumulator clears on acceptance of start.
- Undefined: no checksum byte, no accumulator logic, stream ends after the last register byte.

Test Plan:
- Reset: hold rst=0, pulse clk 5 times -> tx=1, busy=0, done=0, rf_addr=0. Release: outputs unchanged with start=0.
- Basic dump: CLKS_PER_BIT=4, NREGS=4, regs = {0, 7, 0x12345678, 0xFFFFFFFF}, 1-cycle start pulse -> decoded bytes A5 00 00 00 00 07 00 00 00 78 56 34 12 FF FF FF FF. Done pulses exactly 689 cycles after the start edge; busy falls with done.
- Busy-ignore: during the dump above, assert start for 10 cycles mid-byte -> identical byte stream, single done, busy low after done.
- Async reset mid-byte: assert rst=0 during the data bits of byte 6 -> tx=1 and busy=0 with no clock edge needed, no done. A new start yields a full stream from 0xA5.
- Checksum (DUMP_CHECKSUM_EN): same setup as the basic dump -> 18th byte = 0x0F. Done at 689+40 = 729 cycles.
- Continuous start, NREGS=1, regs[0]=0xDEADBEEF: hold start=1 -> repeating frames A5 EF BE AD DE. The next header start bit begins the cycle after each done pulse.

Source files
------------

// File: rtl/regfile_uart_dump.sv
// -----------------------------------------------------------------------------
// regfile_uart_dump
//
// Purpose: on a start request, walks the CPU register file through a spare
// combinational read port and streams its contents over an 8N1 UART TX line.
// The stream is a 0xA5 header byte, then each register 0..NREGS-1 as four
// bytes, least-significant byte first.
//
// Optional feature macro: DUMP_CHECKSUM_EN
//   When defined, one extra byte follows the register bytes. It is the XOR of
//   every register data byte; the header byte is not included.
//   When undefined, the stream ends after the last register byte.
//
// Parameters:
//   CLKS_PER_BIT : clock cycles per UART bit (>= 2)
//   NREGS        : number of registers dumped, addresses 0..NREGS-1 (1..32)
//
// Ports:
//   clk     : system clock; all state changes on the rising edge
//   rst     : asynchronous active-low reset
//   start   : dump request; only looked at while no dump is running
//   rf_addr : register-file read address (registered)
//   rf_data : register-file read data, combinational from rf_addr
//   tx      : UART serial output, idle high
//   busy    : high while a dump is in progress
//   done    : one-cycle pulse in the cycle after the final stop bit
// -----------------------------------------------------------------------------
module regfile_uart_dump #(
  parameter int CLKS_PER_BIT = 868,
  parameter int NREGS        = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic [4:0]  rf_addr,
  input  logic [31:0] rf_data,
  output logic        tx,
  output logic        busy,
  output logic        done
);

  localparam int              CW       = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0]   LAST_CLK = CW'(CLKS_PER_BIT - 1);
  localparam logic [5:0]      LAST_REG = 6'(NREGS - 1);
  localparam logic [7:0]      HDR_BYTE = 8'hA5;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_HDR   = 3'd1,
    S_FETCH = 3'd2,
    S_LATCH = 3'd3,
    S_SEND  = 3'd4,
`ifdef DUMP_CHECKSUM_EN
    S_CKSUM = 3'd5,
`endif
    S_FIN   = 3'd6
  } state_t;

  state_t          state_r;
  logic [CW-1:0]   clk_cnt_r;   // cycles elapsed within the current bit
  logic [3:0]      bit_cnt_r;   // 0 = start bit, 1..8 = data, 9 = stop bit
  logic [1:0]      byte_idx_r;  // byte of the current register being sent
  logic [5:0]      index_r;     // 6 bits so NREGS = 32 ends without wrapping
  logic [8:0]      shift_r;     // {stop bit, data bits not yet sent}
  logic [31:0]     hold_r;      // register value captured in LATCH
`ifdef DUMP_CHECKSUM_EN
  logic [7:0]      cksum_r;

  // XOR of the four bytes of a register word
  function automatic logic [7:0] xor_bytes(input logic [31:0] w);
    return w[7:0] ^ w[15:8] ^ w[23:16] ^ w[31:24];
  endfunction
`endif

  logic bit_end_s;
  logic byte_end_s;

  // End of the current bit period, and end of the stop bit of the byte
  assign bit_end_s  = (clk_cnt_r == LAST_CLK);
  assign byte_end_s = bit_end_s && (bit_cnt_r == 4'd9);

  // Dump sequencer: state, bit timing, serializer and all registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r    <= S_IDLE;
      clk_cnt_r  <= {CW{1'b0}};
      bit_cnt_r  <= 4'd0;
      byte_idx_r <= 2'd0;
      index_r    <= 6'd0;
      shift_r    <= 9'd0;
      hold_r     <= 32'd0;
`ifdef DUMP_CHECKSUM_EN
      cksum_r    <= 8'd0;
`endif
      rf_addr    <= 5'd0;
      tx         <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_r)
        // FIN behaves like IDLE for start, so a held start restarts on the
        // edge right after the done pulse.
        S_IDLE, S_FIN: begin
          if (start) begin
            state_r   <= S_HDR;
            busy      <= 1'b1;
            tx        <= 1'b0;
            shift_r   <= {1'b1, HDR_BYTE};
            clk_cnt_r <= {CW{1'b0}};
            bit_cnt_r <= 4'd0;
            index_r   <= 6'd0;
`ifdef DUMP_CHECKSUM_EN
            cksum_r   <= 8'd0;
`endif
          end else begin
            state_r <= S_IDLE;
            busy    <= 1'b0;
            tx      <= 1'b1;
          end
        end

        // rf_addr was loaded on entry; rf_data settles during this cycle
        S_FETCH: begin
          state_r <= S_LATCH;
        end

        // Capture the register and start its first byte on the next edge
        S_LATCH: begin
          state_r    <= S_SEND;
          hold_r     <= rf_data;
          shift_r    <= {1'b1, rf_data[7:0]};
          tx         <= 1'b0;
          clk_cnt_r  <= {CW{1'b0}};
          bit_cnt_r  <= 4'd0;
          byte_idx_r <= 2'd0;
`ifdef DUMP_CHECKSUM_EN
          cksum_r    <= cksum_r ^ xor_bytes(rf_data);
`endif
        end

        S_HDR,
`ifdef DUMP_CHECKSUM_EN
        S_CKSUM,
`endif
        S_SEND: begin
          if (!bit_end_s) begin
            clk_cnt_r <= clk_cnt_r + CW'(1);
          end else if (!byte_end_s) begin
            // next bit: data LSB first, then the stop bit shifted in as 1
            clk_cnt_r <= {CW{1'b0}};
            tx        <= shift_r[0];
            shift_r   <= {1'b1, shift_r[8:1]};
            bit_cnt_r <= bit_cnt_r + 4'd1;
          end else begin
            clk_cnt_r <= {CW{1'b0}};
            bit_cnt_r <= 4'd0;
            case (state_r)
              S_HDR: begin
                state_r <= S_FETCH;
                rf_addr <= index_r[4:0];
                tx      <= 1'b1;
              end
              S_SEND: begin
                if (byte_idx_r != 2'd3) begin
                  // back-to-back: next start bit begins immediately
                  byte_idx_r <= byte_idx_r + 2'd1;
                  shift_r    <= {1'b1, hold_r[{byte_idx_r + 2'd1, 3'b000} +: 8]};
                  tx         <= 1'b0;
                end else if (index_r != LAST_REG) begin
                  index_r <= index_r + 6'd1;
                  rf_addr <= index_r[4:0] + 5'd1;
                  state_r <= S_FETCH;
                  tx      <= 1'b1;
                end else begin
`ifdef DUMP_CHECKSUM_EN
                  state_r <= S_CKSUM;
                  shift_r <= {1'b1, cksum_r};
                  tx      <= 1'b0;
`else
                  state_r <= S_FIN;
                  done    <= 1'b1;
                  busy    <= 1'b0;
                  tx      <= 1'b1;
`endif
                end
              end
`ifdef DUMP_CHECKSUM_EN
              S_CKSUM: begin
                state_r <= S_FIN;
                done    <= 1'b1;
                busy    <= 1'b0;
                tx      <= 1'b1;
              end
`endif
              default: begin
                state_r <= S_IDLE;
                busy    <= 1'b0;
                tx      <= 1'b1;
              end
            endcase
          end
        end

        default: begin
          state_r <= S_IDLE;
          busy    <= 1'b0;
          tx      <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_uart_dump.sv
// -----------------------------------------------------------------------------
// tb_regfile_uart_dump
//
// Self-checking bench for regfile_uart_dump (CLKS_PER_BIT=4, NREGS=4).
// A bench-side UART receiver decodes tx into bytes; the expected byte stream
// and done latency come from a small model built from the stream format.
// Honors DUMP_CHECKSUM_EN when it is defined for the build.
// -----------------------------------------------------------------------------
module tb_regfile_uart_dump;

  localparam int C = 4;
  localparam int N = 4;
`ifdef DUMP_CHECKSUM_EN
  localparam int CK = 1;
`else
  localparam int CK = 0;
`endif
  localparam int LAT    = 1 + 10*C*(1 + 4*N) + 2*N + CK*10*C;
  localparam int NBYTES = 1 + 4*N + CK;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [4:0]  rf_addr;
  logic [31:0] rf_data;
  logic        tx;
  logic        busy;
  logic        done;

  logic [31:0] regs [0:31];
  assign rf_data = regs[rf_addr];

  regfile_uart_dump #(.CLKS_PER_BIT(C), .NREGS(N)) dut (
    .clk(clk), .rst(rst), .start(start), .rf_addr(rf_addr),
    .rf_data(rf_data), .tx(tx), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int vec_cnt = 0;
  int miss = 0;
  int cyc = 0;
  int done_cnt = 0;
  int done_cyc = 0;
  logic done_busy = 1'b0;
  int rst_epoch = 0;
  int frame_err = 0;
  logic [7:0] rx_q[$];
  logic [7:0] exp_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (done === 1'b1) begin
      done_cnt  <= done_cnt + 1;
      done_cyc  <= cyc;
      done_busy <= busy;
    end
  end

  always @(negedge rst) rst_epoch <= rst_epoch + 1;

  // UART receiver: samples mid-bit on falling clock edges
  initial begin : rx_proc
    logic [7:0] b;
    int ep;
    forever begin
      @(negedge clk);
      if (rst === 1'b1 && tx === 1'b0) begin
        ep = rst_epoch;
        repeat (C/2) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
          repeat (C) @(negedge clk);
          b[i] = tx;
        end
        repeat (C) @(negedge clk);
        if (ep == rst_epoch && rst === 1'b1) begin
          if (tx !== 1'b1) frame_err = frame_err + 1;
          rx_q.push_back(b);
        end
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // Expected stream: header, each register little-endian, optional XOR byte
  task automatic build_exp(input int frames);
    logic [7:0] ck;
    logic [7:0] by;
    exp_q.delete();
    for (int f = 0; f < frames; f++) begin
      exp_q.push_back(8'hA5);
      ck = 8'h00;
      for (int i = 0; i < N; i++) begin
        for (int k = 0; k < 4; k++) begin
          by = 8'((regs[i] / (32'd1 << (8*k))) % 32'd256);
          exp_q.push_back(by);
          ck = ck ^ by;
        end
      end
      if (CK != 0) exp_q.push_back(ck);
    end
  endtask

  task automatic wait_done(input int target, input string nm);
    int t;
    t = 0;
    while (done_cnt < target && t < 4*LAT) begin
      @(negedge clk);
      #1;
      t++;
    end
    chk({nm, "_done_seen"}, 32'(done_cnt >= target), 32'd1);
  endtask

  task automatic cmp_stream(input string nm);
    chk({nm, "_nbytes"}, 32'(rx_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < rx_q.size())
        chk($sformatf("%s_byte%0d", nm, i), 32'(rx_q[i]), 32'(exp_q[i]));
    end
  endtask

  typedef struct {
    logic [31:0] r0, r1, r2, r3;
    bit          noise;
    int          exp_lat;
    int          exp_bytes;
  } vec_t;

  vec_t tbl[4];

  task automatic run_dump(input vec_t v, input string nm);
    int d0;
    int t0;
    regs[0] = v.r0; regs[1] = v.r1; regs[2] = v.r2; regs[3] = v.r3;
    build_exp(1);
    rx_q.delete();
    d0 = done_cnt;
    @(posedge clk); #1 start = 1'b1;
    t0 = cyc;
    @(posedge clk); #1 start = 1'b0;
    chk({nm, "_busy_after_start"}, 32'(busy), 32'd1);
    chk({nm, "_tx_startbit"}, 32'(tx), 32'd0);
    if (v.noise) begin
      repeat (200) @(posedge clk);
      #1 start = 1'b1;
      repeat (10) @(posedge clk);
      #1 start = 1'b0;
    end
    wait_done(d0 + 1, nm);
    chk({nm, "_latency"}, 32'(done_cyc - t0), 32'(v.exp_lat));
    chk({nm, "_busy_with_done"}, 32'(done_busy), 32'd0);
    repeat (20) @(posedge clk);
    #1;
    chk({nm, "_single_done"}, 32'(done_cnt), 32'(d0 + 1));
    chk({nm, "_busy_after"}, 32'(busy), 32'd0);
    chk({nm, "_tx_idle"}, 32'(tx), 32'd1);
    chk({nm, "_nbytes_model"}, 32'(exp_q.size()), 32'(v.exp_bytes));
    cmp_stream(nm);
  endtask

  initial begin : main
    int d0;
    int first;
    int t;
    vec_t ab;

    for (int i = 0; i < 32; i++) regs[i] = 32'd0;

    tbl[0] = '{32'h0, 32'h7, 32'h12345678, 32'hFFFFFFFF, 1'b0, LAT, NBYTES};
    tbl[1] = '{32'h0, 32'h7, 32'h12345678, 32'hFFFFFFFF, 1'b1, LAT, NBYTES};
    tbl[2] = '{$urandom, $urandom, $urandom, $urandom, 1'b0, LAT, NBYTES};
    tbl[3] = '{$urandom, $urandom, $urandom, $urandom, 1'b1, LAT, NBYTES};

    // reset state
    rst = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("rst_tx", 32'(tx), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_rf_addr", 32'(rf_addr), 32'd0);
    @(negedge clk) rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rel_tx", 32'(tx), 32'd1);
    chk("rel_busy", 32'(busy), 32'd0);
    chk("rel_done", 32'(done), 32'd0);
    chk("rel_rf_addr", 32'(rf_addr), 32'd0);

    for (int i = 0; i < 4; i++) run_dump(tbl[i], $sformatf("vec%0d", i));
    chk("rf_addr_holds", 32'(rf_addr), 32'(N - 1));

    // async reset during the data bits of byte 6 (reg1 byte0 = 0x00)
    ab = '{32'h11223344, 32'h0, 32'hCAFEF00D, 32'h5A5A5A5A, 1'b0, LAT, NBYTES};
    regs[0] = ab.r0; regs[1] = ab.r1; regs[2] = ab.r2; regs[3] = ab.r3;
    rx_q.delete();
    d0 = done_cnt;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    t = 0;
    while (rx_q.size() < 5 && t < 4*LAT) begin
      @(posedge clk);
      t++;
    end
    chk("abort_reached_byte6", 32'(rx_q.size() >= 5), 32'd1);
    repeat (3*C) @(posedge clk);
    #2;
    chk("abort_tx_databit", 32'(tx), 32'd0);
    rst = 1'b0;
    #1;
    chk("abort_tx_async", 32'(tx), 32'd1);
    chk("abort_busy_async", 32'(busy), 32'd0);
    repeat (3) @(posedge clk);
    @(negedge clk) rst = 1'b1;
    repeat (LAT + 50) @(posedge clk);
    #1;
    chk("abort_no_done", 32'(done_cnt), 32'(d0));
    chk("abort_idle_busy", 32'(busy), 32'd0);
    chk("abort_idle_tx", 32'(tx), 32'd1);
    run_dump(ab, "after_abort");

    // start held high: frames repeat, next header begins right after done
    regs[0] = 32'hDEADBEEF; regs[1] = $urandom; regs[2] = 32'h0; regs[3] = 32'h80000001;
    build_exp(2);
    rx_q.delete();
    d0 = done_cnt;
    @(posedge clk); #1 start = 1'b1;
    wait_done(d0 + 1, "cont1");
    first = done_cyc;
    @(posedge clk); #1;
    chk("cont_restart_tx", 32'(tx), 32'd0);
    chk("cont_restart_busy", 32'(busy), 32'd1);
    chk("cont_restart_done", 32'(done), 32'd0);
    wait_done(d0 + 2, "cont2");
    start = 1'b0;
    chk("cont_period", 32'(done_cyc - first), 32'(LAT));
    repeat (20) @(posedge clk);
    #1;
    chk("cont_done_count", 32'(done_cnt), 32'(d0 + 2));
    chk("cont_busy_after", 32'(busy), 32'd0);
    cmp_stream("cont");

    chk("framing_errors", 32'(frame_err), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss);
    $finish;
  end

endmodule
